// File: rtl/rv_core_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset core: opcodes, funct fields,
// ALU operation and FSM state enums, and the decoded-control bundle.
package rv_core_pkg;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
    } state_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    use_imm;
        logic    wr_en;
        logic    is_lui;
        logic    is_branch;
        logic    is_bne;
        logic    is_jal;
    } ctrl_t;

endpackage

// File: rtl/rv_alu.sv
// Combinational integer ALU; shift amount comes from the low log2(XLEN) bits of b.
module rv_alu
    import rv_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  y
);

    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] sh;
    assign sh = b[SW-1:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
            ALU_SLL:  y = a << sh;
            ALU_SRL:  y = a >> sh;
            ALU_SRA:  y = $unsigned($signed(a) >>> sh);
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXECUTE/WRITEBACK with a sticky HALT
// on illegal encodings or misaligned control-flow targets.
module rv_multicycle_core
    import rv_core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            retire_valid,
    output logic [XLEN-1:0] retire_pc,
    output logic [4:0]      retire_rd,
    output logic [XLEN-1:0] retire_data,
    output logic            halted,
    output logic            illegal
);

    localparam int RW = $clog2(NREGS);

    state_e          state;
    logic [XLEN-1:0] pc, a, b, r, npc, imm;
    logic [31:0]     ir;
    ctrl_t           ctrl;
    logic            illegal_q;
    logic [XLEN-1:0] regs [NREGS];

    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    function automatic logic reg_bad(input logic [4:0] idx);
        return 32'(idx) >= NREGS;
    endfunction

    // Immediates are built at 32 bits signed, then sign-extended to XLEN.
    logic signed [31:0] imm_i, imm_b, imm_j, imm_u;
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};

    ctrl_t           ctrl_d;
    logic [XLEN-1:0] imm_d;
    logic            dec_ok, use_rs1, use_rs2, use_rd;

    always_comb begin
        ctrl_d        = '0;
        ctrl_d.alu_op = ALU_ADD;
        imm_d         = '0;
        dec_ok        = 1'b0;
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        use_rd        = 1'b0;
        case (opcode)
            OPC_OP: begin
                {use_rs1, use_rs2, use_rd, ctrl_d.wr_en, dec_ok} = 5'b11111;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD_SUB: ctrl_d.alu_op = ALU_ADD;
                        F3_SLL:     ctrl_d.alu_op = ALU_SLL;
                        F3_SLT:     ctrl_d.alu_op = ALU_SLT;
                        F3_SLTU:    ctrl_d.alu_op = ALU_SLTU;
                        F3_XOR:     ctrl_d.alu_op = ALU_XOR;
                        F3_SRL_SRA: ctrl_d.alu_op = ALU_SRL;
                        F3_OR:      ctrl_d.alu_op = ALU_OR;
                        default:    ctrl_d.alu_op = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD_SUB) begin
                    ctrl_d.alu_op = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == F3_SRL_SRA) begin
                    ctrl_d.alu_op = ALU_SRA;
                end else begin
                    dec_ok = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                {use_rs1, use_rd, ctrl_d.wr_en, ctrl_d.use_imm, dec_ok} = 5'b11111;
                imm_d = XLEN'(imm_i);
                case (f3)
                    F3_ADD_SUB: ctrl_d.alu_op = ALU_ADD;
                    F3_SLT:     ctrl_d.alu_op = ALU_SLT;
                    F3_XOR:     ctrl_d.alu_op = ALU_XOR;
                    F3_OR:      ctrl_d.alu_op = ALU_OR;
                    F3_AND:     ctrl_d.alu_op = ALU_AND;
                    default:    dec_ok = 1'b0;
                endcase
            end
            OPC_LUI: begin
                {use_rd, ctrl_d.wr_en, ctrl_d.is_lui, dec_ok} = 4'b1111;
                imm_d = XLEN'(imm_u);
            end
            OPC_BRANCH: begin
                {use_rs1, use_rs2, ctrl_d.is_branch} = 3'b111;
                ctrl_d.is_bne = (f3 == F3_BNE);
                dec_ok        = (f3 == F3_BEQ) || (f3 == F3_BNE);
                imm_d         = XLEN'(imm_b);
            end
            OPC_JAL: begin
                {use_rd, ctrl_d.wr_en, ctrl_d.is_jal, dec_ok} = 4'b1111;
                imm_d = XLEN'(imm_j);
            end
            default: dec_ok = 1'b0;
        endcase
    end

    logic regs_ok;
    assign regs_ok = !(use_rs1 && reg_bad(rs1)) && !(use_rs2 && reg_bad(rs2)) &&
                     !(use_rd && reg_bad(rd));

    logic [XLEN-1:0] op_b, alu_y, pc_plus4, target, npc_d, res_d;
    logic            taken, misalign;

    rv_alu #(.XLEN(XLEN)) u_alu (
        .op (ctrl.alu_op),
        .a  (a),
        .b  (op_b),
        .y  (alu_y)
    );

    assign op_b     = ctrl.use_imm ? imm : b;
    assign pc_plus4 = pc + XLEN'(4);
    assign target   = pc + imm;
    assign taken    = ctrl.is_jal | (ctrl.is_branch & ((a == b) ^ ctrl.is_bne));
    assign npc_d    = taken ? target : pc_plus4;
    assign misalign = taken && (target[1:0] != 2'b00);
    assign res_d    = ctrl.is_jal ? pc_plus4 : (ctrl.is_lui ? imm : alu_y);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            ir          <= '0;
            a           <= '0;
            b           <= '0;
            r           <= '0;
            npc         <= '0;
            imm         <= '0;
            ctrl        <= '0;
            illegal_q   <= 1'b0;
            retire_pc   <= '0;
            retire_rd   <= '0;
            retire_data <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_rvalid) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a    <= regs[rs1[RW-1:0]];
                    b    <= regs[rs2[RW-1:0]];
                    imm  <= imm_d;
                    ctrl <= ctrl_d;
                    if (dec_ok && regs_ok) begin
                        state <= S_EXECUTE;
                    end else begin
                        state     <= S_HALT;
                        illegal_q <= 1'b1;
                    end
                end
                S_EXECUTE: begin
                    r   <= res_d;
                    npc <= npc_d;
                    if (misalign) begin
                        state     <= S_HALT;
                        illegal_q <= 1'b1;
                    end else begin
                        retire_pc   <= pc;
                        retire_rd   <= ctrl.wr_en ? rd : 5'd0;
                        retire_data <= (ctrl.wr_en && rd != 5'd0) ? res_d : '0;
                        state       <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    pc    <= npc;
                    state <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // x0 is never written, so its reset value of zero is what every read returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state == S_WRITEBACK && ctrl.wr_en && rd != 5'd0) begin
            regs[rd[RW-1:0]] <= r;
        end
    end

    assign imem_req     = (state == S_FETCH);
    assign imem_addr    = pc;
    assign retire_valid = (state == S_WRITEBACK);
    assign halted       = (state == S_HALT);
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Scoreboard bench: directed programs push expected retires; a monitor pops and compares.
module tb_rv_multicycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_rvalid, retire_valid, halted, illegal;
    logic [31:0] imem_addr, imem_rdata, retire_pc, retire_data;
    logic [4:0]  retire_rd;

    rv_multicycle_core dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_rd    (retire_rd),
        .retire_data  (retire_data),
        .halted       (halted),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [0:63];
    int          n_checks = 0, n_pass = 0;
    int          minw = 0, maxw = 0, cyc = 0;
    bit          tcheck = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd);
        logic [11:0] im = 12'(imm);
        return {im, 5'(rs1), 3'(f3), 5'(rd), 7'h13};
    endfunction
    function automatic logic [31:0] enc_lui(input int imm20, input int rd);
        return {20'(imm20), 5'(rd), 7'h37};
    endfunction
    function automatic logic [31:0] enc_b(input int off, input int rs2, input int rs1, input int f3);
        logic [12:0] o = 13'(off);
        return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'(f3), o[4:1], o[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input int off, input int rd);
        logic [20:0] o = 21'(off);
        return {o[20], o[10:1], o[11], o[19:12], 5'(rd), 7'h6F};
    endfunction

    task automatic ex(input logic [31:0] pc, input int rd, input logic [31:0] data);
        exp_t e;
        e.pc = pc; e.rd = 5'(rd); e.data = data;
        q.push_back(e);
    endtask

    // Place an instruction at word idx and expect it to retire in program order.
    task automatic put(input int idx, input logic [31:0] ins, input int rd, input logic [31:0] data);
        mem[idx] = ins;
        ex(32'(idx * 4), rd, data);
    endtask

    // Instruction memory with a random per-request wait count in [minw, maxw].
    initial begin : memproc
        int          cnt;
        bit          armed, waited;
        logic [31:0] held;
        imem_rvalid = 1'b0; imem_rdata = '0;
        cnt = 0; armed = 0; waited = 0; held = '0;
        forever begin
            @(negedge clk);
            if (reset || !imem_req) begin
                imem_rvalid = 1'b0;
                armed = 0;
            end else begin
                if (!armed) begin
                    armed = 1; waited = 0; held = imem_addr;
                    cnt = $urandom_range(maxw, minw);
                end
                if (cnt == 0) begin
                    if (waited) check("imem_addr_stable", imem_addr, held);
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem[imem_addr[7:2]];
                    armed = 0;
                end else begin
                    imem_rvalid = 1'b0;
                    cnt--;
                    waited = 1;
                end
            end
        end
    end

    initial begin : monitor
        int   lastc;
        exp_t e;
        lastc = -1;
        forever begin
            @(negedge clk);
            if (reset) begin
                lastc = -1;
            end else if (retire_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_retire: got pc %h rd %0d, expected none", retire_pc, retire_rd);
                end else begin
                    e = q.pop_front();
                    check("retire_pc", retire_pc, e.pc);
                    check("retire_rd", 32'(retire_rd), 32'(e.rd));
                    check("retire_data", retire_data, e.data);
                end
                if (tcheck && lastc >= 0) check("retire_spacing", 32'(cyc - lastc), 32'd4);
                lastc = cyc;
            end
        end
    end

    task automatic begin_test();
        reset = 1'b1;
        q.delete();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000007F;
    endtask

    task automatic end_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_retire_valid", 32'(retire_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_retire_pc", retire_pc, 0);
        check("rst_retire_rd", 32'(retire_rd), 0);
        check("rst_retire_data", retire_data, 0);
        reset = 1'b0;
        #1;
        check("post_rst_imem_req", 32'(imem_req), 1);
        check("post_rst_imem_addr", imem_addr, 0);
    endtask

    task automatic run_drain(input int bound);
        for (int i = 0; i < bound && q.size() > 0; i++) @(posedge clk);
        check("drain_remaining", 32'(q.size()), 0);
    endtask

    task automatic load_p1();
        put(0,  enc_i(5, 0, 0, 1),        1,  32'd5);
        put(1,  enc_i(-3, 0, 0, 2),       2,  32'hFFFF_FFFD);
        put(2,  enc_r(0, 2, 1, 0, 3),     3,  32'd2);
        put(3,  enc_i(1, 0, 0, 5),        5,  32'd1);
        put(4,  enc_r(32, 5, 0, 0, 6),    6,  32'hFFFF_FFFF);
        put(5,  enc_lui(20'h80000, 7),    7,  32'h8000_0000);
        put(6,  enc_i(31, 0, 0, 8),       8,  32'd31);
        put(7,  enc_r(32, 8, 7, 5, 9),    9,  32'hFFFF_FFFF);
        put(8,  enc_r(0, 8, 7, 5, 14),    14, 32'd1);
        put(9,  enc_r(0, 8, 5, 1, 15),    15, 32'h8000_0000);
        put(10, enc_r(0, 6, 5, 3, 10),    10, 32'd1);
        put(11, enc_r(0, 5, 6, 2, 12),    12, 32'd1);
        put(12, enc_i(7, 0, 0, 0),        0,  32'd0);
        put(13, enc_r(0, 5, 0, 0, 11),    11, 32'd1);
        put(14, enc_r(0, 2, 1, 4, 13),    13, 32'hFFFF_FFF8);
        put(15, enc_i(240, 2, 7, 16),     16, 32'h0000_00F0);
        put(16, enc_i(-16, 1, 6, 17),     17, 32'hFFFF_FFF5);
        put(17, enc_i(-2, 2, 2, 18),      18, 32'd1);
    endtask

    initial begin : main
        // Zero-wait memory: ALU coverage plus 4-cycle retire spacing.
        begin_test(); load_p1();
        minw = 0; maxw = 0; tcheck = 1;
        end_reset(); run_drain(300);
        tcheck = 0;

        // Same program with 0..5 wait states per fetch.
        begin_test(); load_p1();
        maxw = 5;
        end_reset(); run_drain(1000);

        // Branches and JAL.
        begin_test();
        mem[0]  = enc_i(5, 0, 0, 1);      mem[1] = enc_i(-3, 0, 0, 2);
        mem[2]  = enc_b(8, 2, 1, 1);      mem[3] = enc_j(12, 0);
        mem[4]  = enc_j(-4, 1);           mem[5] = enc_i(99, 0, 0, 20);
        mem[6]  = enc_b(8, 2, 1, 0);      mem[7] = enc_r(0, 0, 1, 0, 3);
        mem[8]  = enc_b(8, 0, 0, 0);      mem[9] = enc_i(77, 0, 0, 21);
        mem[10] = enc_i(1, 0, 0, 4);
        ex(32'h00, 1, 32'd5);  ex(32'h04, 2, 32'hFFFF_FFFD); ex(32'h08, 0, 0);
        ex(32'h10, 1, 32'h14); ex(32'h0C, 0, 0);             ex(32'h18, 0, 0);
        ex(32'h1C, 3, 32'h14); ex(32'h20, 0, 0);             ex(32'h28, 4, 32'd1);
        maxw = 3;
        end_reset(); run_drain(600);

        // Illegal opcode after one good instruction.
        begin_test();
        put(0, enc_i(1, 0, 0, 1), 1, 32'd1);
        minw = 0; maxw = 0;
        end_reset(); run_drain(100);
        repeat (3) @(negedge clk);
        check("illop_halted", 32'(halted), 1);
        check("illop_illegal", 32'(illegal), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("illop_quiet", {30'd0, imem_req, retire_valid}, 0);
        end

        // JAL to a misaligned target: halt with no retire.
        begin_test();
        mem[0] = enc_j(2, 1);
        end_reset();
        repeat (8) @(negedge clk);
        check("jal2_halted", 32'(halted), 1);
        check("jal2_illegal", 32'(illegal), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("jal2_quiet", {30'd0, imem_req, retire_valid}, 0);
        end

        // Reset while a fetch is pending: state and registers start over.
        begin_test();
        put(0, enc_r(0, 2, 1, 0, 3), 3, 32'd0);
        put(1, enc_i(5, 0, 0, 1),    1, 32'd5);
        put(2, enc_i(7, 0, 0, 2),    2, 32'd7);
        put(3, enc_r(0, 2, 1, 0, 3), 3, 32'd12);
        mem[4] = enc_i(9, 0, 0, 5);
        minw = 3; maxw = 5;
        end_reset(); run_drain(400);
        @(posedge clk);
        @(negedge clk);
        check("pending_req", 32'(imem_req), 1);
        check("pending_addr", imem_addr, 32'h10);
        #2 reset = 1'b1;
        ex(32'h00, 3, 32'd0); ex(32'h04, 1, 32'd5); ex(32'h08, 2, 32'd7);
        ex(32'h0C, 3, 32'd12); ex(32'h10, 5, 32'd9);
        minw = 0;
        end_reset(); run_drain(600);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
